// File: rtl/spi_prom_responder.sv
// SPI mode-0 peripheral emulating a 25AA128-style board EEPROM.
// The SPI pins are oversampled on sysclk, and the block is backed by a 2^ADDR_BITS byte memory.
module spi_prom_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int PAGE_BITS    = 6,
  parameter int WRITE_CYCLES = 1000
) (
  input  logic sysclk,
  input  logic reset,
  input  logic prom_sclk,
  input  logic prom_mosi,
  input  logic prom_cs,
  output logic prom_miso,
  output logic prom_miso_oe,
  output logic busy
);
  localparam int CW = $clog2(WRITE_CYCLES + 1);
  localparam logic [ADDR_BITS-1:0] PMASK = ADDR_BITS'((1 << PAGE_BITS) - 1);
  localparam logic [7:0] OP_WRITE = 8'h02, OP_READ = 8'h03, OP_WRDI = 8'h04,
                         OP_RDSR  = 8'h05, OP_WREN = 8'h06;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR_HI, ADDR_LO, DATA_RD, DATA_WR, STATUS, IGNORE
  } state_t;

  state_t state, state_nx;

  logic [2:0]           sclk_s, cs_s;
  logic [1:0]           mosi_s;
  logic [7:0]           mem [2**ADDR_BITS];
  logic [6:0]           sr;
  logic [7:0]           tx;
  logic [2:0]           bit_cnt;
  logic [ADDR_BITS-1:0] addr;
  logic [CW-1:0]        cnt;
  logic                 wel, wr_ok, wr_any, cmd_rd;

  logic                 sclk_rise, sclk_fall, cs_low, cs_fall, cs_rise;
  logic                 byte_done, wip, mem_we, drive_nx;
  logic [7:0]           rx_byte, status;
  logic [ADDR_BITS-1:0] addr_load, addr_inc, addr_page;

  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign sclk_fall = ~sclk_s[1] & sclk_s[2];
  assign cs_low    = ~cs_s[1];
  assign cs_fall   = cs_low & cs_s[2];
  assign cs_rise   = cs_s[1] & ~cs_s[2];
  assign rx_byte   = {sr, mosi_s[1]};
  assign byte_done = cs_low & sclk_rise & (bit_cnt == 3'd7) & (state != IDLE);
  assign wip       = (cnt != '0);
  assign busy      = wip;
  // WIP as it will be next cycle, so a status byte loaded on expiry shows it clear
  assign status    = {6'b0, wel, (cnt > CW'(1))};
  assign addr_load = ADDR_BITS'({addr, rx_byte});
  assign addr_inc  = addr + ADDR_BITS'(1);
  assign addr_page = (addr & ~PMASK) | (addr_inc & PMASK);
  assign mem_we    = byte_done & (state == DATA_WR) & wr_ok;
  assign drive_nx  = (state_nx == DATA_RD) | (state_nx == STATUS);

  always_ff @(posedge sysclk) begin
    sclk_s <= {sclk_s[1:0], prom_sclk};
    cs_s   <= {cs_s[1:0], prom_cs};
    mosi_s <= {mosi_s[0], prom_mosi};
  end

  always_ff @(posedge sysclk) begin
    if (mem_we) mem[addr] <= rx_byte;
  end

  always_ff @(posedge sysclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // IDLE only leaves on a cs falling edge, so a frame cut by reset is ignored
  always_comb begin
    state_nx = state;
    if (!cs_low) state_nx = IDLE;
    else begin
      unique case (state)
        IDLE:    if (cs_fall) state_nx = CMD;
        CMD:     if (byte_done) begin
          if (wip && rx_byte != OP_RDSR) state_nx = IGNORE;
          else begin
            unique case (rx_byte)
              OP_RDSR:           state_nx = STATUS;
              OP_READ, OP_WRITE: state_nx = ADDR_HI;
              default:           state_nx = IGNORE;
            endcase
          end
        end
        ADDR_HI: if (byte_done) state_nx = ADDR_LO;
        ADDR_LO: if (byte_done) state_nx = cmd_rd ? DATA_RD : DATA_WR;
        default: ;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      wel          <= 1'b0;
      cnt          <= '0;
      bit_cnt      <= '0;
      sr           <= '0;
      tx           <= '0;
      addr         <= '0;
      wr_ok        <= 1'b0;
      wr_any       <= 1'b0;
      cmd_rd       <= 1'b0;
      prom_miso    <= 1'b0;
      prom_miso_oe <= 1'b0;
    end else begin
      if (wip) cnt <= cnt - CW'(1);
      prom_miso_oe <= drive_nx;
      if (!drive_nx) prom_miso <= 1'b0;
      else if (sclk_fall) begin
        prom_miso <= tx[7];
        tx        <= {tx[6:0], 1'b0};
      end
      if (!cs_low) begin
        bit_cnt <= '0;
        wr_any  <= 1'b0;
        if (cs_rise && state == DATA_WR && wr_any) begin
          wel <= 1'b0;
          cnt <= CW'(WRITE_CYCLES);
        end
      end else if (sclk_rise && state != IDLE) begin
        sr      <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          unique case (state)
            CMD: begin
              cmd_rd <= (rx_byte == OP_READ);
              wr_ok  <= wel;
              tx     <= status;
              if (!wip && rx_byte == OP_WREN) wel <= 1'b1;
              if (!wip && rx_byte == OP_WRDI) wel <= 1'b0;
            end
            ADDR_HI: addr <= addr_load;
            ADDR_LO: begin
              addr <= addr_load;
              tx   <= mem[addr_load];
            end
            DATA_RD: begin
              addr <= addr_inc;
              tx   <= mem[addr_inc];
            end
            DATA_WR: begin
              addr <= addr_page;
              if (wr_ok) wr_any <= 1'b1;
            end
            STATUS:  tx <= status;
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_prom_responder.sv
// Directed bench for spi_prom_responder: drives SPI mode-0 frames as the initiator
// and compares the returned bytes, output enable and busy against hand-computed values.
`timescale 1ns/1ps
module tb_spi_prom_responder;
  localparam int HALF = 80;
  localparam int WC   = 1000;

  logic sysclk = 1'b0, reset = 1'b1, sclk = 1'b0, mosi = 1'b0, cs = 1'b1;
  logic miso, miso_oe, busy;
  int   n_chk = 0, n_pass = 0, cyc = 0, t0;
  logic [7:0] q, oeb;

  spi_prom_responder #(.ADDR_BITS(8), .PAGE_BITS(6), .WRITE_CYCLES(WC)) dut (
    .sysclk(sysclk), .reset(reset), .prom_sclk(sclk), .prom_mosi(mosi),
    .prom_cs(cs), .prom_miso(miso), .prom_miso_oe(miso_oe), .busy(busy)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge sysclk);
    #2;
  endtask

  task automatic xfer(input int nb, input logic [7:0] d, output logic [7:0] r, output logic [7:0] o);
    r = '0;
    o = '0;
    for (int i = 7; i >= 8 - nb; i--) begin
      mosi = d[i];
      #(HALF);
      r[i] = miso;
      o[i] = miso_oe;
      sclk = 1'b1;
      #(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic sel();
    cs = 1'b0;
    #(HALF);
  endtask

  task automatic desel();
    #(HALF);
    cs = 1'b1;
    #(3*HALF);
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] r, o;
    xfer(8, b, r, o);
  endtask

  task automatic cmd1(input logic [7:0] c);
    sel(); send(c); desel();
  endtask

  task automatic hdr(input logic [7:0] c, input logic [15:0] a);
    sel(); send(c); send(a[15:8]); send(a[7:0]);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] exp);
    xfer(8, 8'h00, q, oeb);
    chk(tag, q, exp);
  endtask

  task automatic rdsr_chk(input string tag, input logic [7:0] exp);
    logic [7:0] o;
    sel();
    xfer(8, 8'h05, q, o);
    chk({tag, "_cmd_oe"}, o, 8'h00);
    xfer(8, 8'h00, q, oeb);
    chk(tag, q, exp);
    chk({tag, "_oe"}, oeb, 8'hFF);
    #(HALF);
    cs = 1'b1;
    #35;
    chk({tag, "_oe_drop"}, miso_oe, 1'b0);
    #(3*HALF - 35);
  endtask

  task automatic wait_clear(input string tag);
    int i = 0;
    while (busy && i < 2*WC) begin
      cycles(1);
      i++;
    end
    chk(tag, busy, 1'b0);
  endtask

  initial begin
    #600us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cycles(5);
    reset = 1'b0;
    cycles(2);
    chk("rst_oe", miso_oe, 1'b0);
    chk("rst_miso", miso, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rdsr_chk("rdsr_rst", 8'h00);

    cmd1(8'h06);
    rdsr_chk("rdsr_wren", 8'h02);
    sel(); send(8'h05); rd_chk("rdsr_rep0", 8'h02); rd_chk("rdsr_rep1", 8'h02); desel();
    cmd1(8'h04);
    rdsr_chk("rdsr_wrdi", 8'h00);

    // committed write, WIP length, read back
    cmd1(8'h06);
    hdr(8'h02, 16'h0010); send(8'hA5); send(8'h5A);
    #(HALF);
    cs = 1'b1;
    t0 = cyc;
    #(3*HALF);
    rdsr_chk("rdsr_wip", 8'h01);
    chk("busy_wip", busy, 1'b1);
    while (cyc < t0 + 995) cycles(1);
    chk("busy_late", busy, 1'b1);
    wait_clear("wip_clear");
    chk("wip_len", ((cyc - t0) >= 1000 && (cyc - t0) <= 1006), 1'b1);
    rdsr_chk("rdsr_done", 8'h00);
    hdr(8'h03, 16'h0010); rd_chk("rd_10", 8'hA5); rd_chk("rd_11", 8'h5A); desel();

    // write protection and WREN during WIP
    cmd1(8'h06); hdr(8'h02, 16'h0020); send(8'h33); desel(); wait_clear("wp_pre");
    hdr(8'h02, 16'h0020); send(8'h11); desel();
    chk("wp_busy", busy, 1'b0);
    hdr(8'h03, 16'h0020); rd_chk("wp_read", 8'h33); desel();
    cmd1(8'h06); hdr(8'h02, 16'h0021); send(8'h44); desel();
    chk("wip2_busy", busy, 1'b1);
    cmd1(8'h06);
    wait_clear("wip2_clear");
    rdsr_chk("wren_in_wip", 8'h00);

    // page wrap on write, address wrap and aliasing on read
    cmd1(8'h06);
    hdr(8'h02, 16'h003E); send(8'h01); send(8'h02); send(8'h03); send(8'h04); desel();
    wait_clear("pg_clear");
    hdr(8'h03, 16'h003E); rd_chk("pg_3e", 8'h01); rd_chk("pg_3f", 8'h02); desel();
    hdr(8'h03, 16'h0000); rd_chk("pg_00", 8'h03); rd_chk("pg_01", 8'h04); desel();
    cmd1(8'h06); hdr(8'h02, 16'h00FF); send(8'hAA); desel(); wait_clear("ff_clear");
    hdr(8'h03, 16'h00FF);
    rd_chk("rw_ff", 8'hAA); rd_chk("rw_00", 8'h03); rd_chk("rw_01", 8'h04);
    desel();
    hdr(8'h03, 16'h1210); rd_chk("alias", 8'hA5); desel();

    // abort mid third data byte
    cmd1(8'h06); hdr(8'h02, 16'h0082); send(8'h77); desel(); wait_clear("ab_pre");
    cmd1(8'h06);
    hdr(8'h02, 16'h0080); send(8'hC1); send(8'hC2); xfer(5, 8'hC3, q, oeb); desel();
    wait_clear("ab_clear");
    hdr(8'h03, 16'h0080);
    rd_chk("ab_80", 8'hC1); rd_chk("ab_81", 8'hC2); rd_chk("ab_82", 8'h77);
    desel();

    // WRITE with no data bytes keeps WEL and starts no WIP
    cmd1(8'h06); hdr(8'h02, 16'h0090); desel();
    chk("zw_busy", busy, 1'b0);
    rdsr_chk("zw_rdsr", 8'h02);
    cmd1(8'h04);

    // reset in the middle of a READ
    hdr(8'h03, 16'h0010); xfer(3, 8'h00, q, oeb);
    chk("mid_oe_pre", miso_oe, 1'b1);
    cycles(1);
    reset = 1'b1;
    cycles(1);
    chk("mid_oe_rst", miso_oe, 1'b0);
    reset = 1'b0;
    xfer(8, 8'h00, q, oeb);
    chk("mid_ignore", oeb, 8'h00);
    desel();
    hdr(8'h03, 16'h0010); rd_chk("post_rst", 8'hA5); desel();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
